tms34020_mem_arb: RTL and testbench
===================================

# tms34020_mem_arb

Memory-cycle arbiter for the TMS34020 core. Sits between the I/O register/video block, the CPU bus interface and the external memory port, and schedules three requesters onto the single memory bus: screen-refresh (VRAM read-transfer) requests, DRAM refresh cycles generated from an internal timer, and CPU accesses. It owns the refresh timer, the refresh row counter and the pending-request bookkeeping. It presents one cycle at a time to memory with a request/ready handshake.

## Interface
- No parameters.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  global enable; when 0, all state freezes.
- CE_R  in  1  processor clock-enable; all arbitration, timer and handshake sampling occur only on CLK edges with EN&&CE_R.
- SCRREF_RUN  in  1  one-CE_R-tick pulse requesting a screen-refresh transfer.
- SCRREF_ADDR  in  32  transfer address; valid with SCRREF_RUN.
- RR  in  2  refresh rate: 00 = every 32 ticks, 01 = 64, 10 = 128, 11 = refresh disabled.
- CPU_REQ  in  1  level CPU request; held until CPU_ACK.
- CPU_WE  in  1  1 = write.
- CPU_ADDR  in  32  CPU address.
- CPU_BE  in  4  byte enables.
- CPU_DI  in  32  write data.
- CPU_DO  out  32  read data; captured from MEM_DI at read completion; reset 0.
- CPU_ACK  out  1  one-CLK pulse at CPU cycle completion; reset 0.
- MEM_REQ  out  1  memory cycle active; reset 0.
- MEM_CYC  out  2  00 CPU read, 01 CPU write, 10 screen transfer, 11 DRAM refresh; reset 00.
- MEM_ADDR  out  32  cycle address; reset 0.
- MEM_BE  out  4  byte enables (4'hF for transfer/refresh); reset 0.
- MEM_DO  out  32  write data (CPU_DI for writes, else 0); reset 0.
- MEM_DI  in  32  read data from memory.
- MEM_RDY  in  1  memory completes current cycle.
- REF_ROW  out  16  refresh row counter; reset 0.
- SRT_OVR  out  1  sticky: a screen request arrived while one was already pending; reset 0; cleared only by reset.

## Operation
- States: IDLE, BUSY. Reset -> IDLE.
- Screen-request latch: one slot. On SCRREF_RUN, set SRT_PEND and store SCRREF_ADDR. If SRT_PEND is already set and not being granted in the same tick, overwrite the address and set SRT_OVR.
- Refresh timer: 7-bit, counts ticks. At period-1 it wraps to 0 and REF_PEND (2-bit, saturating at 3) increments. RR=11 holds the timer at 0 and generates no new requests; existing REF_PEND is still serviced. An RR change does not reset the timer, but a timer value >= the new period wraps to 0 on the next tick and counts as an expiry.
- Arbitration in IDLE, priority high to low:
  - SRT_PEND.
  - REF_PEND==3 (urgent).
  - CPU_REQ.
  - REF_PEND!=0.
- Grant: MEM_CYC, MEM_ADDR, MEM_BE and MEM_DO are loaded, MEM_REQ is set and the state goes to BUSY. On a screen grant, SRT_PEND is cleared. On a refresh grant, MEM_ADDR = {16'h0000, REF_ROW}.
- BUSY: outputs are held stable. On a tick with MEM_RDY=1:
  - MEM_REQ is cleared and the state returns to IDLE.
  - CPU cycle: CPU_ACK pulses; for reads, CPU_DO <= MEM_DI.
  - Refresh: REF_PEND decrements and REF_ROW increments, wrapping FFFF->0000.
- Simultaneous refresh expiry and refresh completion in one tick: REF_PEND unchanged.
- Simultaneous SCRREF_RUN and screen completion: the new request latches normally with no overflow.
- CPU_REQ dropped while BUSY on a CPU cycle: the cycle still completes and ACK still pulses.

## Timing
- Request sampled on tick k -> grant registered at tick k, MEM_REQ high from the next CLK.
- Earliest completion is tick k+1 with MEM_RDY=1. Next grant no earlier than tick k+2, so the minimum is 2 ticks per cycle.
- CPU_ACK is exactly one CLK wide, coincident with MEM_REQ falling.
- SCRREF_RUN latched on tick k can be granted on tick k+1 (not tick k).
- RST_N low at any point: immediate return to reset values and IDLE. An in-flight cycle is abandoned with no ACK.
- EN=0: no state change, outputs held.

## Test plan
- CPU read, MEM_RDY after 3 ticks, MEM_DI=32'hDEADBEEF -> MEM_CYC=00 for 4 ticks, one CPU_ACK pulse, CPU_DO=32'hDEADBEEF.
- CPU_REQ and SCRREF_RUN (addr 32'h0012_3400) pending in the same IDLE tick -> screen cycle first with MEM_CYC=10 and MEM_ADDR=32'h0012_3400, then the CPU cycle.
- RR=00, CPU_REQ held continuously, MEM_RDY=1 -> refresh deferred until REF_PEND=3 (after 96 ticks), then MEM_CYC=11 preempts the CPU; REF_ROW increments.
- RR=00, memory stalled (MEM_RDY=0) for 200 ticks -> REF_PEND saturates at 3; after release, three refreshes complete and REF_ROW=3.
- Two SCRREF_RUN pulses while BUSY on a long CPU cycle -> SRT_OVR=1; the single screen cycle uses the second address.
- Preload REF_ROW=16'hFFFF, complete one refresh -> REF_ROW=0. Assert RST_N low mid-BUSY -> MEM_REQ=0, no CPU_ACK, all outputs at reset values.

Source files
------------

// File: rtl/tms34020_mem_arb_if.sv
// External memory port of the TMS34020 memory-cycle arbiter: one cycle at a time,
// request/ready handshake. The master drives the cycle; the slave returns data and ready.
interface tms34020_mem_arb_if;
    logic        mem_req;
    logic [1:0]  mem_cyc;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_do;
    logic [31:0] mem_di;
    logic        mem_rdy;

    modport master (
        output mem_req, mem_cyc, mem_addr, mem_be, mem_do,
        input  mem_di, mem_rdy
    );

    modport slave (
        input  mem_req, mem_cyc, mem_addr, mem_be, mem_do,
        output mem_di, mem_rdy
    );
endinterface

// File: rtl/tms34020_mem_arb.sv
// Memory-cycle arbiter: schedules screen transfers, DRAM refresh and CPU accesses onto the
// single memory port, and owns the refresh timer, refresh row counter and pending requests.
module tms34020_mem_arb (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      ce_r,
    input  logic                      scrref_run,
    input  logic [31:0]               scrref_addr,
    input  logic [1:0]                rr,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [3:0]                cpu_be,
    input  logic [31:0]               cpu_di,
    output logic [31:0]               cpu_do,
    output logic                      cpu_ack,
    output logic [15:0]               ref_row,
    output logic                      srt_ovr,
    tms34020_mem_arb_if.master        mem
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [1:0] CycRd  = 2'b00;
    localparam logic [1:0] CycWr  = 2'b01;
    localparam logic [1:0] CycScr = 2'b10;
    localparam logic [1:0] CycRef = 2'b11;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [1:0]  cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_do_q, cpu_do_d;
    logic        ack_q, ack_d;
    logic [6:0]  timer_q, timer_d;
    logic [1:0]  ref_pend_q, ref_pend_d;
    logic [15:0] ref_row_q, ref_row_d;
    logic        srt_pend_q, srt_pend_d;
    logic [31:0] srt_addr_q, srt_addr_d;
    logic        srt_ovr_q, srt_ovr_d;

    logic        tick;
    logic [6:0]  period_m1;
    logic        ref_expire;
    logic        ref_done;
    logic        grant_scr;

    assign tick = en & ce_r;

    always_comb begin
        period_m1 = 7'd0;
        unique case (rr)
            2'b00:   period_m1 = 7'd31;
            2'b01:   period_m1 = 7'd63;
            2'b10:   period_m1 = 7'd127;
            default: period_m1 = 7'd0;
        endcase
    end

    // A timer left above a shortened period wraps at once and counts as an expiry.
    always_comb begin
        timer_d    = timer_q;
        ref_expire = 1'b0;
        if (rr == 2'b11) begin
            timer_d = 7'd0;
        end else if (timer_q >= period_m1) begin
            timer_d    = 7'd0;
            ref_expire = 1'b1;
        end else begin
            timer_d = timer_q + 7'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cyc_d     = cyc_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cpu_do_d  = cpu_do_q;
        ack_d     = 1'b0;
        ref_done  = 1'b0;
        grant_scr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (srt_pend_q) begin
                    grant_scr = 1'b1;
                    state_d   = StBusy;
                    req_d     = 1'b1;
                    cyc_d     = CycScr;
                    addr_d    = srt_addr_q;
                    be_d      = 4'hF;
                    wdata_d   = 32'h0;
                end else if (ref_pend_q == 2'd3 || (!cpu_req && ref_pend_q != 2'd0)) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    cyc_d   = CycRef;
                    addr_d  = {16'h0000, ref_row_q};
                    be_d    = 4'hF;
                    wdata_d = 32'h0;
                end else if (cpu_req) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    cyc_d   = cpu_we ? CycWr : CycRd;
                    addr_d  = cpu_addr;
                    be_d    = cpu_be;
                    wdata_d = cpu_we ? cpu_di : 32'h0;
                end
            end
            StBusy: begin
                if (mem.mem_rdy) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    if (cyc_q == CycRd || cyc_q == CycWr) begin
                        ack_d = 1'b1;
                    end
                    if (cyc_q == CycRd) begin
                        cpu_do_d = mem.mem_di;
                    end
                    if (cyc_q == CycRef) begin
                        ref_done = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ref_pend_d = ref_pend_q;
        if (ref_expire && !ref_done && ref_pend_q != 2'd3) begin
            ref_pend_d = ref_pend_q + 2'd1;
        end else if (ref_done && !ref_expire) begin
            ref_pend_d = ref_pend_q - 2'd1;
        end
        ref_row_d = ref_done ? ref_row_q + 16'd1 : ref_row_q;
    end

    // A request arriving while the slot is being granted refills it without overflow.
    always_comb begin
        srt_pend_d = srt_pend_q & ~grant_scr;
        srt_addr_d = srt_addr_q;
        srt_ovr_d  = srt_ovr_q;
        if (scrref_run) begin
            srt_pend_d = 1'b1;
            srt_addr_d = scrref_addr;
            if (srt_pend_q && !grant_scr) begin
                srt_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            cyc_q      <= 2'b00;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            cpu_do_q   <= 32'h0;
            ack_q      <= 1'b0;
            timer_q    <= 7'd0;
            ref_pend_q <= 2'd0;
            ref_row_q  <= 16'h0;
            srt_pend_q <= 1'b0;
            srt_addr_q <= 32'h0;
            srt_ovr_q  <= 1'b0;
        end else if (en) begin
            // The ack pulse lasts a single clock even when the following edge is not a tick.
            ack_q <= 1'b0;
            if (tick) begin
                state_q    <= state_d;
                req_q      <= req_d;
                cyc_q      <= cyc_d;
                addr_q     <= addr_d;
                be_q       <= be_d;
                wdata_q    <= wdata_d;
                cpu_do_q   <= cpu_do_d;
                ack_q      <= ack_d;
                timer_q    <= timer_d;
                ref_pend_q <= ref_pend_d;
                ref_row_q  <= ref_row_d;
                srt_pend_q <= srt_pend_d;
                srt_addr_q <= srt_addr_d;
                srt_ovr_q  <= srt_ovr_d;
            end
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_cyc  = cyc_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_be   = be_q;
    assign mem.mem_do   = wdata_q;
    assign cpu_do       = cpu_do_q;
    assign cpu_ack      = ack_q;
    assign ref_row      = ref_row_q;
    assign srt_ovr      = srt_ovr_q;

endmodule

// File: tb/tb_tms34020_mem_arb.sv
// Directed bench for tms34020_mem_arb: arbitration order, handshake timing, refresh
// bookkeeping, screen-request overflow, enable freeze and asynchronous reset.
module tb_tms34020_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ce_r;
    logic        scrref_run;
    logic [31:0] scrref_addr;
    logic [1:0]  rr;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_di;
    logic [31:0] cpu_do;
    logic        cpu_ack;
    logic [15:0] ref_row;
    logic        srt_ovr;

    int checks = 0;
    int errors = 0;

    tms34020_mem_arb_if mem_bus ();

    tms34020_mem_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ce_r        (ce_r),
        .scrref_run  (scrref_run),
        .scrref_addr (scrref_addr),
        .rr          (rr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_be      (cpu_be),
        .cpu_di      (cpu_di),
        .cpu_do      (cpu_do),
        .cpu_ack     (cpu_ack),
        .ref_row     (ref_row),
        .srt_ovr     (srt_ovr),
        .mem         (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; ce_r = 1'b1; scrref_run = 1'b0; scrref_addr = 32'h0; rr = 2'b11;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_be = 4'h0; cpu_di = 32'h0;
        mem_bus.mem_di = 32'h0; mem_bus.mem_rdy = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
             mem_bus.mem_do} !== 71'h0) begin
            errors++;
            $display("FAIL reset_mem got req=%b cyc=%b addr=%h be=%h do=%h want all 0",
                     mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
                     mem_bus.mem_do);
        end
        checks++;
        if ({cpu_do, cpu_ack, ref_row, srt_ovr} !== 50'h0) begin
            errors++;
            $display("FAIL reset_misc got do=%h ack=%b row=%h ovr=%b want all 0",
                     cpu_do, cpu_ack, ref_row, srt_ovr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        int hi = 0;
        int acks = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100; cpu_be = 4'hF;
        mem_bus.mem_di = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            mem_bus.mem_rdy = (i == 4);
            tick();
            if (mem_bus.mem_req && mem_bus.mem_cyc == 2'b00) hi++;
            if (cpu_ack) begin
                acks++;
                cpu_req = 1'b0;
            end
        end
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL read_busy_ticks got %0d want 4", hi);
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL read_ack_count got %0d want 1", acks);
        end
        checks++;
        if (cpu_do !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_data got %h want deadbeef", cpu_do);
        end
    endtask

    task automatic test_screen_priority();
        mem_bus.mem_rdy = 1'b0;
        scrref_run = 1'b1; scrref_addr = 32'h0012_3400;
        tick();
        scrref_run = 1'b0;
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL scr_not_same_tick got req=%b want 0", mem_bus.mem_req);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0200; cpu_be = 4'h3;
        cpu_di = 32'hA5A5_5A5A;
        tick();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be} !==
            {1'b1, 2'b10, 32'h0012_3400, 4'hF}) begin
            errors++;
            $display("FAIL scr_first got req=%b cyc=%b addr=%h be=%h want 1 10 00123400 f",
                     mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be);
        end
        mem_bus.mem_rdy = 1'b1;
        tick();
        checks++;
        if ({mem_bus.mem_req, cpu_ack} !== 2'b00) begin
            errors++;
            $display("FAIL scr_done got req=%b ack=%b want 0 0", mem_bus.mem_req, cpu_ack);
        end
        mem_bus.mem_rdy = 1'b0;
        tick();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
             mem_bus.mem_do} !== {1'b1, 2'b01, 32'h0000_0200, 4'h3, 32'hA5A5_5A5A}) begin
            errors++;
            $display("FAIL cpu_after_scr got req=%b cyc=%b addr=%h be=%h do=%h",
                     mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
                     mem_bus.mem_do);
        end
        mem_bus.mem_rdy = 1'b1;
        tick();
        checks++;
        if ({mem_bus.mem_req, cpu_ack} !== 2'b01) begin
            errors++;
            $display("FAIL cpu_write_ack got req=%b ack=%b want 0 1", mem_bus.mem_req, cpu_ack);
        end
        cpu_req = 1'b0;
        mem_bus.mem_rdy = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        rr = 2'b11; cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0400; cpu_be = 4'hC;
        cpu_di = 32'h1234_5678;
        tick();
        checks++;
        if ({mem_bus.mem_cyc, mem_bus.mem_be, mem_bus.mem_do} !== {2'b01, 4'hC, 32'h1234_5678})
        begin
            errors++;
            $display("FAIL en_write_grant got cyc=%b be=%h do=%h want 01 c 12345678",
                     mem_bus.mem_cyc, mem_bus.mem_be, mem_bus.mem_do);
        end
        en = 1'b0; mem_bus.mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mem_bus.mem_req, cpu_ack} !== 2'b10) begin
                errors++;
                $display("FAIL en_freeze got req=%b ack=%b want 1 0", mem_bus.mem_req, cpu_ack);
            end
        end
        en = 1'b1; ce_r = 1'b0;
        tick();
        checks++;
        if ({mem_bus.mem_req, cpu_ack} !== 2'b10) begin
            errors++;
            $display("FAIL ce_freeze got req=%b ack=%b want 1 0", mem_bus.mem_req, cpu_ack);
        end
        ce_r = 1'b1;
        tick();
        checks++;
        if ({mem_bus.mem_req, cpu_ack} !== 2'b01) begin
            errors++;
            $display("FAIL en_resume got req=%b ack=%b want 0 1", mem_bus.mem_req, cpu_ack);
        end
        cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_width got ack=%b want 0", cpu_ack);
        end
    endtask

    task automatic test_overflow();
        rr = 2'b11; cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300; cpu_be = 4'hF;
        tick();
        scrref_run = 1'b1; scrref_addr = 32'h1111_0000;
        tick();
        scrref_run = 1'b0;
        checks++;
        if (srt_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got %b want 0", srt_ovr);
        end
        tick();
        scrref_run = 1'b1; scrref_addr = 32'h2222_0000;
        tick();
        scrref_run = 1'b0;
        checks++;
        if (srt_ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second got %b want 1", srt_ovr);
        end
        mem_bus.mem_rdy = 1'b1;
        tick();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL ovr_cpu_ack got %b want 1", cpu_ack);
        end
        cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        tick();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr} !==
            {1'b1, 2'b10, 32'h2222_0000}) begin
            errors++;
            $display("FAIL ovr_scr_addr got req=%b cyc=%b addr=%h want 1 10 22220000",
                     mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr);
        end
        mem_bus.mem_rdy = 1'b1;
        tick();
        mem_bus.mem_rdy = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_bus.mem_req, srt_ovr} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_single_cycle got req=%b ovr=%b want 0 1", mem_bus.mem_req, srt_ovr);
        end
    endtask

    task automatic test_refresh_defer();
        int first = 0;
        logic [31:0] addr_seen = 32'hFFFF_FFFF;
        logic [15:0] row98 = 16'hFFFF;
        rr = 2'b00; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_be = 4'hF;
        mem_bus.mem_rdy = 1'b1;
        apply_reset();
        for (int t = 1; t <= 110; t++) begin
            tick();
            if (first == 0 && mem_bus.mem_req && mem_bus.mem_cyc == 2'b11) begin
                first = t;
                addr_seen = mem_bus.mem_addr;
            end
            if (t == 98) row98 = ref_row;
        end
        checks++;
        if (first !== 97) begin
            errors++;
            $display("FAIL ref_urgent_tick got %0d want 97", first);
        end
        checks++;
        if (addr_seen !== 32'h0) begin
            errors++;
            $display("FAIL ref_addr got %h want 00000000", addr_seen);
        end
        checks++;
        if (row98 !== 16'd1) begin
            errors++;
            $display("FAIL ref_row_inc got %h want 0001", row98);
        end
        cpu_req = 1'b0; rr = 2'b11; mem_bus.mem_rdy = 1'b0;
    endtask

    task automatic test_refresh_saturate();
        int done = 0;
        logic prev = 1'b1;
        rr = 2'b00; cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        apply_reset();
        for (int t = 1; t <= 200; t++) tick();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc} !== 3'b111) begin
            errors++;
            $display("FAIL sat_stalled got req=%b cyc=%b want 1 11",
                     mem_bus.mem_req, mem_bus.mem_cyc);
        end
        mem_bus.mem_rdy = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (prev && !mem_bus.mem_req && mem_bus.mem_cyc == 2'b11) done++;
            prev = mem_bus.mem_req;
        end
        checks++;
        if (done !== 3) begin
            errors++;
            $display("FAIL sat_count got %0d want 3", done);
        end
        checks++;
        if (ref_row !== 16'd3) begin
            errors++;
            $display("FAIL sat_row got %h want 0003", ref_row);
        end
        rr = 2'b11; mem_bus.mem_rdy = 1'b0;
    endtask

    task automatic test_row_wrap();
        logic [31:0] addr_seen = 32'h0;
        rr = 2'b11; cpu_req = 1'b0; mem_bus.mem_rdy = 1'b1;
        apply_reset();
        dut.ref_row_q = 16'hFFFF;
        rr = 2'b00;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (mem_bus.mem_req && mem_bus.mem_cyc == 2'b11) addr_seen = mem_bus.mem_addr;
        end
        checks++;
        if (addr_seen !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL wrap_addr got %h want 0000ffff", addr_seen);
        end
        checks++;
        if (ref_row !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_row got %h want 0000", ref_row);
        end
        rr = 2'b11; mem_bus.mem_rdy = 1'b0;
    endtask

    task automatic test_reset_midbusy();
        int acks = 0;
        rr = 2'b11; cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_be = 4'hF;
        mem_bus.mem_di = 32'hCAFE_F00D;
        tick();
        mem_bus.mem_rdy = 1'b1;
        tick();
        cpu_req = 1'b0; mem_bus.mem_rdy = 1'b0;
        checks++;
        if (cpu_do !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL midrst_pre_data got %h want cafef00d", cpu_do);
        end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0600; cpu_be = 4'h5;
        cpu_di = 32'h0BAD_CAFE;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
             mem_bus.mem_do, cpu_do, cpu_ack, ref_row, srt_ovr} !== 121'h0) begin
            errors++;
            $display("FAIL midrst_outputs got req=%b cyc=%b addr=%h be=%h do=%h cdo=%h ack=%b",
                     mem_bus.mem_req, mem_bus.mem_cyc, mem_bus.mem_addr, mem_bus.mem_be,
                     mem_bus.mem_do, cpu_do, cpu_ack);
        end
        cpu_req = 1'b0; mem_bus.mem_rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack || mem_bus.mem_req) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL midrst_no_ack got %0d active ticks want 0", acks);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_screen_priority();
        test_enable();
        test_overflow();
        test_refresh_defer();
        test_refresh_saturate();
        test_row_wrap();
        test_reset_midbusy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
